trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
// - M/U-mode trap controller for the small RV32 core: arbitrates synchronous exceptions, machine interrupts, MRET and WFI.
// - Sequences pipeline flush, trap-CSR update (mepc/mcause/mtval/mstatus/mode) and PC redirect.
// - Sits between execute stage, CSR file and fetch; the CSR file owns storage and applies csr_we updates.
// PARAMETERS
// - RESET_VECTOR  32'h0000_0000  redirect_pc value while idle / after reset (no functional use)
// PORTS
// - reset         in   1   synchronous, active-high
// - clock         in   1   rising edge
// - exc_valid     in   1   execute-stage exception this cycle
// - exc_cause     in   4   except_* code
// - exc_pc        in   32  PC of faulting instruction
// - exc_tval      in   32  fault address / instruction bits
// - mret_valid    in   1   MRET retiring
// - wfi_valid     in   1   WFI retiring
// - irq_pc        in   32  PC of oldest unretired instruction (mepc for interrupts)
// - irq_msip/mtip/meip  in  1 each  pending lines (mip)
// - mie_msie/mtie/meie  in  1 each  enable bits (mie)
// - mstatus_mie, mstatus_mpie  in  1 each; mstatus_mpp  in  2
// - cur_mode      in   2   u_mode / m_mode
// - mtvec, mepc_in  in  32 each
// - flush_ack     in   1   pipeline drained
// - flush_req     out  1   request pipeline drain
// - busy          out  1   stall fetch/issue
// - wfi_sleep     out  1   core sleeping
// - csr_we        out  1   one-cycle trap-CSR write strobe
// - mepc_out, mcause_out, mtval_out  out  32 each
// - mie_next, mpie_next  out  1 each; mpp_next, mode_next  out  2 each
// - redirect_valid  out  1; redirect_pc  out  32
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0 except redirect_pc=RESET_VECTOR; latched cause/pc/tval cleared. Reset in any state aborts to IDLE next cycle.
// - irq_en = mstatus_mie | (cur_mode==u_mode); pend = {meip&meie, msip&msie, mtip&mtie}; priority MEI > MSI > MTI (codes 4'hB, 4'h3, 4'h7).
// - IDLE accept priority: exc_valid > pending interrupt (irq_en & |pend) > mret_valid > wfi_valid. On accept latch kind, cause, epc (exc_pc or irq_pc), tval (exc_tval; 0 for irq).
// - States: IDLE -> FLUSH on exception/interrupt/mret; IDLE -> SLEEP on wfi.
// - FLUSH: flush_req=1, busy=1; stays until flush_ack; -> ENTER (trap) or RETURN (mret). New events ignored; latched cause kept even if pend drops.
// - ENTER (1 cycle): csr_we=1; mepc_out={epc[31:1],1'b0}; mcause_out={int,27'b0,cause}; mtval_out=tval; mpie_next=mstatus_mie; mie_next=0; mpp_next=cur_mode; mode_next=m_mode. -> REDIRECT.
// - RETURN (1 cycle): csr_we=1; mie_next=mstatus_mpie; mpie_next=1; mode_next=mstatus_mpp; mpp_next=u_mode. -> REDIRECT.
// - REDIRECT (1 cycle): redirect_valid=1, busy=1. Trap: base={mtvec[31:2],2'b00}; mtvec[1:0]==1 && interrupt -> base+{cause,2'b00}; else base. MRET: {mepc_in[31:1],1'b0}. -> IDLE.
// - SLEEP: wfi_sleep=1, busy=1; exit to IDLE when |pend (independent of irq_en); interrupt then taken from IDLE only if irq_en. exc/mret/wfi ignored.
// - Latency: accept cycle N -> flush_req N+1; flush_ack at M -> csr_we M+1, redirect_valid M+2, IDLE M+3. flush_ack already high at N+1 gives 4-cycle trap.
// - csr_we and redirect_valid never high in same cycle; each exactly one pulse per trap/mret.
// - Arithmetic: vector add 32-bit wrap-around, no carry-out.
// STRUCTURE
// - Shared constants package: trap_state_t enum {IDLE,FLUSH,ENTER,RETURN,REDIRECT,SLEEP}; mtvec mode constants (direct=2'b00, vectored=2'b01); reuse interrupt_mach_*, except_*, u_mode/m_mode.
// - Sub-module trap_priority: combinational pend/exception encoder -> {take, int_flag, cause}. FSM and latches in top.
// TESTING
// - Reset mid-FLUSH (exc accepted, reset pulsed before flush_ack) -> IDLE next cycle, no csr_we, no redirect.
// - exc_valid cause 4'h2, exc_pc 32'h100, tval 32'hDEAD, mtvec 32'h200, flush_ack at N+1 -> csr_we N+2 (mcause 32'h2, mepc 32'h100, mtval 32'hDEAD, mie_next 0, mpie_next 1), redirect_pc 32'h200 at N+3.
// - meip+mtip pending, enables on, mstatus_mie=1, mtvec 32'h301 -> mcause 32'h8000_000B, mepc=irq_pc, redirect_pc 32'h32C.
// - exc_valid and meip in same cycle -> exception taken (mcause bit31=0); interrupt taken in following trap.
// - M-mode mstatus_mie=0, mtip pending+enabled, wfi_valid -> SLEEP exits next cycle to IDLE, no trap; cur_mode=u_mode same setup -> trap taken.
// - mret_valid, mpie=1, mpp=u_mode, mepc_in 32'h403 -> mie_next 1, mpie_next 1, mode_next u_mode, mpp_next u_mode, redirect_pc 32'h402.

Source files
------------

// File: rtl/trap_sequencer_pkg.sv
// ============================================================================
// Module      : trap_sequencer_pkg
// Description : Shared types and constants for the M/U-mode trap sequencer:
//               sequencer state encoding, mtvec modes, privilege modes,
//               machine interrupt codes and synchronous exception codes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package trap_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FLUSH    = 3'd1,
    ENTER    = 3'd2,
    RETURN   = 3'd3,
    REDIRECT = 3'd4,
    SLEEP    = 3'd5
  } trap_state_t;

  // mtvec[1:0] modes
  localparam logic [1:0] mtvec_direct   = 2'b00;
  localparam logic [1:0] mtvec_vectored = 2'b01;

  // privilege modes
  localparam logic [1:0] u_mode = 2'b00;
  localparam logic [1:0] m_mode = 2'b11;

  // machine interrupt cause codes
  localparam logic [3:0] interrupt_mach_soft  = 4'h3;
  localparam logic [3:0] interrupt_mach_timer = 4'h7;
  localparam logic [3:0] interrupt_mach_ext   = 4'hB;

  // synchronous exception cause codes
  localparam logic [3:0] except_inst_misaligned  = 4'h0;
  localparam logic [3:0] except_inst_access      = 4'h1;
  localparam logic [3:0] except_illegal_inst     = 4'h2;
  localparam logic [3:0] except_breakpoint       = 4'h3;
  localparam logic [3:0] except_load_misaligned  = 4'h4;
  localparam logic [3:0] except_load_access      = 4'h5;
  localparam logic [3:0] except_store_misaligned = 4'h6;
  localparam logic [3:0] except_store_access     = 4'h7;
  localparam logic [3:0] except_ecall_u          = 4'h8;
  localparam logic [3:0] except_ecall_m          = 4'hB;

  // Arbitration result of the priority encoder.
  typedef struct packed {
    logic       take;
    logic       int_flag;
    logic [3:0] cause;
  } trap_req_t;

  // Trap target: vectored mode offsets interrupts by 4*cause, 32-bit wrap.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic        int_flag,
                                              input logic [3:0]  cause);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if ((mtvec[1:0] == mtvec_vectored) && int_flag)
      trap_target = base + {26'd0, cause, 2'b00};
    else
      trap_target = base;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_sequencer_priority.sv
// ============================================================================
// Module      : trap_priority
// Description : Combinational trap arbiter. A synchronous exception always
//               wins; otherwise the highest-priority enabled pending machine
//               interrupt (MEI > MSI > MTI) is taken when interrupts are
//               globally enabled for the current mode.
// Ports       : exc_valid/exc_cause - execute-stage exception
//               irq_en              - global interrupt enable for this mode
//               pend                - {mei, msi, mti} pending & enabled
//               req                 - {take, int_flag, cause}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_priority
  import trap_sequencer_pkg::*;
(
  input  logic       exc_valid,
  input  logic [3:0] exc_cause,
  input  logic       irq_en,
  input  logic [2:0] pend,
  output trap_req_t  req
);

  always_comb begin
    req = '0;
    if (exc_valid) begin
      req.take     = 1'b1;
      req.int_flag = 1'b0;
      req.cause    = exc_cause;
    end else if (irq_en && (|pend)) begin
      req.take     = 1'b1;
      req.int_flag = 1'b1;
      if (pend[2])
        req.cause = interrupt_mach_ext;
      else if (pend[1])
        req.cause = interrupt_mach_soft;
      else
        req.cause = interrupt_mach_timer;
    end
  end

endmodule

`default_nettype wire

// File: rtl/trap_sequencer.sv
// ============================================================================
// Module      : trap_sequencer
// Description : M/U-mode trap controller. Accepts exceptions, interrupts,
//               MRET and WFI in IDLE, drains the pipeline, emits a single
//               trap-CSR write strobe and then a single PC redirect.
// Ports       : clock/reset (sync, active-high)
//               exc_*, irq_*, mie_*, mstatus_*, cur_mode, mtvec, mepc_in in
//               flush_ack in; flush_req, busy, wfi_sleep out
//               csr_we + mepc/mcause/mtval/mie/mpie/mpp/mode next values out
//               redirect_valid/redirect_pc out
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret_valid,
  input  logic        wfi_valid,
  input  logic [31:0] irq_pc,
  input  logic        irq_msip,
  input  logic        irq_mtip,
  input  logic        irq_meip,
  input  logic        mie_msie,
  input  logic        mie_mtie,
  input  logic        mie_meie,
  input  logic        mstatus_mie,
  input  logic        mstatus_mpie,
  input  logic [1:0]  mstatus_mpp,
  input  logic [1:0]  cur_mode,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc_in,
  input  logic        flush_ack,
  output logic        flush_req,
  output logic        busy,
  output logic        wfi_sleep,
  output logic        csr_we,
  output logic [31:0] mepc_out,
  output logic [31:0] mcause_out,
  output logic [31:0] mtval_out,
  output logic        mie_next,
  output logic        mpie_next,
  output logic [1:0]  mpp_next,
  output logic [1:0]  mode_next,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  trap_state_t state, state_next;

  // Event captured at accept time; held for the rest of the sequence.
  logic        int_q;
  logic        mret_q;
  logic [3:0]  cause_q;
  logic [31:0] epc_q;
  logic [31:0] tval_q;

  logic [2:0]  pend;
  logic        irq_en;
  trap_req_t   req;

  assign pend   = {irq_meip & mie_meie, irq_msip & mie_msie, irq_mtip & mie_mtie};
  assign irq_en = mstatus_mie | (cur_mode == u_mode);

  trap_priority u_priority (
    .exc_valid (exc_valid),
    .exc_cause (exc_cause),
    .irq_en    (irq_en),
    .pend      (pend),
    .req       (req)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      int_q   <= 1'b0;
      mret_q  <= 1'b0;
      cause_q <= 4'd0;
      epc_q   <= 32'd0;
      tval_q  <= 32'd0;
    end else begin
      state <= state_next;
      if (state == IDLE) begin
        if (req.take) begin
          int_q   <= req.int_flag;
          mret_q  <= 1'b0;
          cause_q <= req.cause;
          epc_q   <= req.int_flag ? irq_pc : exc_pc;
          tval_q  <= req.int_flag ? 32'd0 : exc_tval;
        end else if (mret_valid) begin
          mret_q  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_next     = state;
    flush_req      = 1'b0;
    busy           = 1'b0;
    wfi_sleep      = 1'b0;
    csr_we         = 1'b0;
    mepc_out       = 32'd0;
    mcause_out     = 32'd0;
    mtval_out      = 32'd0;
    mie_next       = 1'b0;
    mpie_next      = 1'b0;
    mpp_next       = u_mode;
    mode_next      = u_mode;
    redirect_valid = 1'b0;
    redirect_pc    = RESET_VECTOR;

    unique case (state)
      IDLE: begin
        if (req.take || mret_valid)
          state_next = FLUSH;
        else if (wfi_valid)
          state_next = SLEEP;
      end

      FLUSH: begin
        flush_req = 1'b1;
        busy      = 1'b1;
        if (flush_ack)
          state_next = mret_q ? RETURN : ENTER;
      end

      ENTER: begin
        busy       = 1'b1;
        csr_we     = 1'b1;
        mepc_out   = epc_q & 32'hFFFF_FFFE;
        mcause_out = {int_q, 27'd0, cause_q};
        mtval_out  = tval_q;
        mpie_next  = mstatus_mie;
        mie_next   = 1'b0;
        mpp_next   = cur_mode;
        mode_next  = m_mode;
        state_next = REDIRECT;
      end

      RETURN: begin
        busy       = 1'b1;
        csr_we     = 1'b1;
        mie_next   = mstatus_mpie;
        mpie_next  = 1'b1;
        mode_next  = mstatus_mpp;
        mpp_next   = u_mode;
        state_next = REDIRECT;
      end

      REDIRECT: begin
        busy           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = mret_q ? (mepc_in & 32'hFFFF_FFFE)
                                : trap_target(mtvec, int_q, cause_q);
        state_next     = IDLE;
      end

      SLEEP: begin
        wfi_sleep = 1'b1;
        busy      = 1'b1;
        // Any enabled pending line wakes the core, even with interrupts
        // globally disabled; IDLE then decides whether to trap.
        if (|pend)
          state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none

module tb_trap_sequencer;

  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        exc_valid = 0, mret_valid = 0, wfi_valid = 0, flush_ack = 0;
  logic [3:0]  exc_cause = 0;
  logic [31:0] exc_pc = 0, exc_tval = 0, irq_pc = 0, mtvec = 0, mepc_in = 0;
  logic        irq_msip = 0, irq_mtip = 0, irq_meip = 0;
  logic        mie_msie = 0, mie_mtie = 0, mie_meie = 0;
  logic        mstatus_mie = 0, mstatus_mpie = 0;
  logic [1:0]  mstatus_mpp = 0, cur_mode = 0;

  logic        flush_req, busy, wfi_sleep, csr_we, mie_next, mpie_next, redirect_valid;
  logic [31:0] mepc_out, mcause_out, mtval_out, redirect_pc;
  logic [1:0]  mpp_next, mode_next;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  trap_sequencer #(.RESET_VECTOR(RV)) dut (
    .clock(clock), .reset(reset),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_pc(exc_pc), .exc_tval(exc_tval),
    .mret_valid(mret_valid), .wfi_valid(wfi_valid), .irq_pc(irq_pc),
    .irq_msip(irq_msip), .irq_mtip(irq_mtip), .irq_meip(irq_meip),
    .mie_msie(mie_msie), .mie_mtie(mie_mtie), .mie_meie(mie_meie),
    .mstatus_mie(mstatus_mie), .mstatus_mpie(mstatus_mpie), .mstatus_mpp(mstatus_mpp),
    .cur_mode(cur_mode), .mtvec(mtvec), .mepc_in(mepc_in), .flush_ack(flush_ack),
    .flush_req(flush_req), .busy(busy), .wfi_sleep(wfi_sleep), .csr_we(csr_we),
    .mepc_out(mepc_out), .mcause_out(mcause_out), .mtval_out(mtval_out),
    .mie_next(mie_next), .mpie_next(mpie_next), .mpp_next(mpp_next), .mode_next(mode_next),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic        exc;
    logic [3:0]  cause;
    logic [31:0] epc, tval, ipc;
    logic        msip, mtip, meip, msie, mtie, meie;
    logic        smie, smpie;
    logic [1:0]  mpp, mode;
    logic [31:0] tvec, mepc;
    logic        mret, wfi;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        is_mret;
    logic [31:0] mcause, mepc, mtval, rpc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic stim_t base_stim();
    stim_t s;
    s = '{default: '0};
    s.smie = 1'b1;
    s.mode = 2'b11;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exc_valid = s.exc; exc_cause = s.cause; exc_pc = s.epc; exc_tval = s.tval;
    irq_pc = s.ipc;
    irq_msip = s.msip; irq_mtip = s.mtip; irq_meip = s.meip;
    mie_msie = s.msie; mie_mtie = s.mtie; mie_meie = s.meie;
    mstatus_mie = s.smie; mstatus_mpie = s.smpie; mstatus_mpp = s.mpp;
    cur_mode = s.mode; mtvec = s.tvec; mepc_in = s.mepc;
    mret_valid = s.mret; wfi_valid = s.wfi;
  endtask

  // Reference decision straight from the architectural rules.
  // kind: 0 none, 1 trap, 2 mret, 3 wfi
  task automatic model(input stim_t s, output int kind, output logic [31:0] mc,
                       output logic [31:0] ep, output logic [31:0] tv, output logic [31:0] rpc);
    bit          en;
    int          code;
    logic [31:0] base;
    en   = s.smie || (s.mode == 2'b00);
    code = -1;
    if (s.meip && s.meie) code = 11;
    else if (s.msip && s.msie) code = 3;
    else if (s.mtip && s.mtie) code = 7;
    base = s.tvec & 32'hFFFF_FFFC;
    kind = 0; mc = 0; ep = 0; tv = 0; rpc = 0;
    if (s.exc) begin
      kind = 1; mc = {28'd0, s.cause}; ep = s.epc & 32'hFFFF_FFFE; tv = s.tval; rpc = base;
    end else if (en && code >= 0) begin
      kind = 1; mc = 32'h8000_0000 + code; ep = s.ipc & 32'hFFFF_FFFE; tv = 0;
      rpc = (s.tvec[1:0] == 2'b01) ? base + 4 * code : base;
    end else if (s.mret) begin
      kind = 2; rpc = s.mepc & 32'hFFFF_FFFE;
    end else if (s.wfi) begin
      kind = 3;
    end
  endtask

  // Inputs describing the event are already driven; the next edge accepts it.
  task automatic run_seq(input logic is_mret, input logic [31:0] emc, input logic [31:0] eep,
                         input logic [31:0] etv, input logic [31:0] erpc, input int dly,
                         input logic keep_pend);
    @(posedge clock); #1;
    exc_valid = 0; mret_valid = 0; wfi_valid = 0;
    if (!keep_pend) begin irq_meip = 0; irq_msip = 0; irq_mtip = 0; end
    for (int d = 0; d <= dly; d++) begin
      chk("flush_req", flush_req, 1);
      chk("flush_busy", busy, 1);
      chk("flush_csr_we", csr_we, 0);
      chk("flush_redirect", redirect_valid, 0);
      flush_ack = (d == dly);
      @(posedge clock); #1;
    end
    flush_ack = 0;
    chk("csr_we", csr_we, 1);
    chk("csr_redirect", redirect_valid, 0);
    chk("csr_flush_req", flush_req, 0);
    if (is_mret) begin
      chk("ret_mie", mie_next, mstatus_mpie);
      chk("ret_mpie", mpie_next, 1);
      chk("ret_mode", mode_next, mstatus_mpp);
      chk("ret_mpp", mpp_next, 2'b00);
    end else begin
      chk("mcause", mcause_out, emc);
      chk("mepc", mepc_out, eep);
      chk("mtval", mtval_out, etv);
      chk("ent_mie", mie_next, 0);
      chk("ent_mpie", mpie_next, mstatus_mie);
      chk("ent_mpp", mpp_next, cur_mode);
      chk("ent_mode", mode_next, 2'b11);
    end
    @(posedge clock); #1;
    chk("redirect_valid", redirect_valid, 1);
    chk("redirect_pc", redirect_pc, erpc);
    chk("redir_csr_we", csr_we, 0);
    chk("redir_busy", busy, 1);
    @(posedge clock); #1;
    chk("idle_redirect", redirect_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_csr_we", csr_we, 0);
    chk("idle_pc", redirect_pc, RV);
  endtask

  vec_t        tbl[7];
  stim_t       s;
  int          kind;
  logic [31:0] mc, ep, tv, rpc;

  initial begin
    // ---------------- reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_flush_req", flush_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sleep", wfi_sleep, 0);
    chk("rst_csr_we", csr_we, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_pc", redirect_pc, RV);
    chk("rst_mcause", mcause_out, 0);
    reset = 0;

    // ---------------- table-driven single events
    for (int i = 0; i < 7; i++) begin tbl[i].s = base_stim(); tbl[i].is_mret = 0; end
    tbl[0].s.exc = 1; tbl[0].s.cause = 4'h2; tbl[0].s.epc = 32'h100; tbl[0].s.tval = 32'hDEAD;
    tbl[0].s.tvec = 32'h200;
    tbl[0].mcause = 32'h2; tbl[0].mepc = 32'h100; tbl[0].mtval = 32'hDEAD; tbl[0].rpc = 32'h200;
    tbl[1].s.meip = 1; tbl[1].s.mtip = 1; tbl[1].s.meie = 1; tbl[1].s.mtie = 1; tbl[1].s.msie = 1;
    tbl[1].s.tvec = 32'h301; tbl[1].s.ipc = 32'h1234;
    tbl[1].mcause = 32'h8000_000B; tbl[1].mepc = 32'h1234; tbl[1].mtval = 0; tbl[1].rpc = 32'h32C;
    tbl[2].s.mret = 1; tbl[2].s.smpie = 1; tbl[2].s.mpp = 2'b00; tbl[2].s.mepc = 32'h403;
    tbl[2].is_mret = 1; tbl[2].mcause = 0; tbl[2].mepc = 0; tbl[2].mtval = 0; tbl[2].rpc = 32'h402;
    tbl[3].s.exc = 1; tbl[3].s.cause = 4'h5; tbl[3].s.epc = 32'h107; tbl[3].s.tval = 32'h55;
    tbl[3].s.tvec = 32'h301;
    tbl[3].mcause = 32'h5; tbl[3].mepc = 32'h106; tbl[3].mtval = 32'h55; tbl[3].rpc = 32'h300;
    tbl[4].s.msip = 1; tbl[4].s.msie = 1; tbl[4].s.mode = 2'b00; tbl[4].s.smie = 0;
    tbl[4].s.tvec = 32'h401; tbl[4].s.ipc = 32'h2000;
    tbl[4].mcause = 32'h8000_0003; tbl[4].mepc = 32'h2000; tbl[4].mtval = 0; tbl[4].rpc = 32'h40C;
    tbl[5].s.mtip = 1; tbl[5].s.mtie = 1; tbl[5].s.tvec = 32'hFFFF_FFF1; tbl[5].s.ipc = 32'h3;
    tbl[5].mcause = 32'h8000_0007; tbl[5].mepc = 32'h2; tbl[5].mtval = 0; tbl[5].rpc = 32'hC;
    tbl[6].s.meip = 1; tbl[6].s.msip = 1; tbl[6].s.mtip = 1;
    tbl[6].s.meie = 1; tbl[6].s.msie = 1; tbl[6].s.mtie = 1; tbl[6].s.tvec = 32'h1; tbl[6].s.ipc = 32'h40;
    tbl[6].mcause = 32'h8000_000B; tbl[6].mepc = 32'h40; tbl[6].mtval = 0; tbl[6].rpc = 32'h2C;
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].s);
      run_seq(tbl[i].is_mret, tbl[i].mcause, tbl[i].mepc, tbl[i].mtval, tbl[i].rpc, 0, 0);
    end

    // ---------------- reset during FLUSH aborts the trap
    s = base_stim(); s.exc = 1; s.cause = 4'h1; s.tvec = 32'h80;
    drive(s);
    @(posedge clock); #1;
    exc_valid = 0;
    chk("midflush_req", flush_req, 1);
    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    chk("abort_flush_req", flush_req, 0);
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_csr_we", csr_we, 0);
      chk("abort_redirect", redirect_valid, 0);
      @(posedge clock); #1;
    end

    // ---------------- exception and interrupt together: exception first
    s = base_stim(); s.exc = 1; s.cause = 4'h4; s.epc = 32'h500; s.tval = 32'h77;
    s.meip = 1; s.meie = 1; s.ipc = 32'h600; s.tvec = 32'h201;
    drive(s);
    run_seq(0, 32'h4, 32'h500, 32'h77, 32'h200, 1, 1);
    run_seq(0, 32'h8000_000B, 32'h600, 32'h0, 32'h22C, 0, 0);

    // ---------------- WFI wake without trap (M-mode, MIE=0), then U-mode trap
    s = base_stim(); s.smie = 0; s.mtip = 1; s.mtie = 1; s.wfi = 1; s.tvec = 32'h100;
    s.ipc = 32'h700;
    drive(s);
    @(posedge clock); #1;
    wfi_valid = 0;
    chk("wfi_sleep", wfi_sleep, 1);
    chk("wfi_busy", busy, 1);
    @(posedge clock); #1;
    chk("wake_sleep", wfi_sleep, 0);
    chk("wake_busy", busy, 0);
    @(posedge clock); #1;
    chk("wake_no_trap", flush_req, 0);
    cur_mode = 2'b00; wfi_valid = 1;
    run_seq(0, 32'h8000_0007, 32'h700, 32'h0, 32'h100, 0, 0);

    // ---------------- randomized transactions against the reference model
    for (int it = 0; it < 120; it++) begin
      s.exc  = ($urandom_range(0, 3) == 0);
      s.cause = 4'($urandom);
      s.epc  = $urandom; s.tval = $urandom; s.ipc = $urandom;
      s.msip = ($urandom_range(0, 2) == 0); s.mtip = ($urandom_range(0, 2) == 0);
      s.meip = ($urandom_range(0, 2) == 0);
      s.msie = 1'($urandom); s.mtie = 1'($urandom); s.meie = 1'($urandom);
      s.smie = 1'($urandom); s.smpie = 1'($urandom);
      s.mpp  = $urandom_range(0, 1) ? 2'b11 : 2'b00;
      s.mode = $urandom_range(0, 1) ? 2'b11 : 2'b00;
      s.tvec = $urandom; s.mepc = $urandom;
      s.mret = ($urandom_range(0, 2) == 0);
      s.wfi  = ($urandom_range(0, 2) == 0);
      model(s, kind, mc, ep, tv, rpc);
      drive(s);
      if (kind == 1 || kind == 2) begin
        run_seq(kind == 2, mc, ep, tv, rpc, $urandom_range(0, 3), 0);
      end else if (kind == 0) begin
        @(posedge clock); #1;
        chk("rnd_none_busy", busy, 0);
        chk("rnd_none_flush", flush_req, 0);
        chk("rnd_none_sleep", wfi_sleep, 0);
        irq_meip = 0; irq_msip = 0; irq_mtip = 0;
      end else begin
        int k;
        int line;
        @(posedge clock); #1;
        exc_valid = 0; mret_valid = 0; wfi_valid = 0;
        irq_meip = 0; irq_msip = 0; irq_mtip = 0;
        k = $urandom_range(1, 3);
        line = $urandom_range(0, 2);
        for (int i = 0; i < k; i++) begin
          chk("rnd_sleep", wfi_sleep, 1);
          chk("rnd_sleep_busy", busy, 1);
          chk("rnd_sleep_flush", flush_req, 0);
          if (i == k - 1) begin
            s.meip = 0; s.msip = 0; s.mtip = 0; s.exc = 0; s.mret = 0; s.wfi = 0;
            if (line == 0) begin s.meip = 1; s.meie = 1; end
            else if (line == 1) begin s.msip = 1; s.msie = 1; end
            else begin s.mtip = 1; s.mtie = 1; end
            drive(s);
          end
          @(posedge clock); #1;
        end
        chk("rnd_wake_sleep", wfi_sleep, 0);
        chk("rnd_wake_busy", busy, 0);
        model(s, kind, mc, ep, tv, rpc);
        if (kind == 1) begin
          run_seq(0, mc, ep, tv, rpc, $urandom_range(0, 3), 0);
        end else begin
          irq_meip = 0; irq_msip = 0; irq_mtip = 0;
          @(posedge clock); #1;
          chk("rnd_wake_no_trap", flush_req, 0);
          chk("rnd_wake_idle", busy, 0);
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
